// File: rtl/inst_axi_bridge.sv
// Purpose: bridges the IF-stage SRAM-like fetch port to a single-ID AXI read channel.
// Latency: addr_ok at N -> arvalid at N+1; R handshake at M -> data_ok/rdata at M+1.
// Backpressure: addr_ok is withheld while AR is pending or the outstanding budget is full; rready drops when nothing is outstanding.
module inst_axi_bridge #(
  parameter int         OUTSTANDING_MAX = 2,
  parameter logic [3:0] AXI_ID          = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic {AR_IDLE = 1'b0, AR_BUSY = 1'b1} ar_state_t;

  localparam logic [1:0] CNT_MAX = 2'(OUTSTANDING_MAX);

  ar_state_t   ar_state;
  logic [1:0]  cnt;
  logic [31:0] araddr_q;
  logic [1:0]  size_q;
  logic        arvalid_q;
  logic        data_ok_q;
  logic [31:0] rdata_q;
  logic        r_hs;
  logic        unused_ok;

  // Single ID means in-order return, so the R-side identity and response code carry no information here.
  assign unused_ok = &{1'b0, rid, rresp};

  assign r_hs              = rvalid && rready;
  assign inst_sram_addr_ok = inst_sram_req && ~inst_sram_wr && ~arvalid_q && (cnt < CNT_MAX);
  assign rready            = (cnt != 2'd0);

  assign arid              = AXI_ID;
  assign arlen             = 8'd0;
  assign arburst           = 2'b01;
  assign araddr            = araddr_q;
  assign arsize            = {1'b0, size_q};
  assign arvalid           = arvalid_q;
  assign inst_sram_data_ok = data_ok_q;
  assign inst_sram_rdata   = rdata_q;

  // AR channel FSM: latch the accepted fetch and hold it on AR until the slave takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ar_state  <= AR_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= 32'h0;
      size_q    <= 2'd0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (inst_sram_addr_ok) begin
            ar_state  <= AR_BUSY;
            arvalid_q <= 1'b1;
            araddr_q  <= inst_sram_addr;
            size_q    <= inst_sram_size;
          end
        end
        AR_BUSY: begin
          if (arready) begin
            ar_state  <= AR_IDLE;
            arvalid_q <= 1'b0;
          end
        end
        default: begin
          ar_state  <= AR_IDLE;
          arvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding counter: accepted-but-unreturned fetches, saturating at both ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 2'd0;
    end else begin
      case ({inst_sram_addr_ok, r_hs})
        2'b10:   if (cnt != CNT_MAX) cnt <= cnt + 2'd1;
        2'b01:   if (cnt != 2'd0)    cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Return path: capture each R beat and flag it to the IF stage for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      data_ok_q <= r_hs;
      if (r_hs) rdata_q <= rdata;
    end
  end

endmodule

// File: tb/tb_inst_axi_bridge.sv
module tb_inst_axi_bridge;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  int tests = 0;
  int fails = 0;

  // Scoreboard of instruction words the IF stage should see, in request order.
  logic [31:0] dat_exp_q[$];
  // Accepted fetches whose AR has not yet been taken by the slave.
  logic [31:0] ar_addr_q[$];
  logic [1:0]  ar_size_q[$];
  // Addresses the slave has accepted and still owes data for.
  logic [31:0] slv_q[$];
  int          out_cnt = 0;
  logic        prev_rhs = 1'b0;

  inst_axi_bridge #(.OUTSTANDING_MAX(MAX), .AXI_ID(4'd0)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every data_ok pulse must match the oldest expected instruction word.
  always @(posedge clk) begin
    #1;
    if (inst_sram_data_ok === 1'b1) begin
      if (dat_exp_q.size() == 0) begin
        chk("spurious_data_ok", 32'd1, 32'd0);
      end else begin
        chk("rdata_order", inst_sram_rdata, dat_exp_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    inst_sram_req  = 1'b0;
    inst_sram_wr   = 1'b0;
    inst_sram_size = 2'd0;
    inst_sram_addr = 32'h0;
    arready        = 1'b0;
    rvalid         = 1'b0;
    rdata          = 32'h0;
    rid            = 4'hf;
    rresp          = 2'b10;
  endtask

  // One randomized cycle driven against the queue-based reference model.
  task automatic rand_cycle(input bit gen);
    logic exp_ok, rhs, ar_hs;
    @(negedge clk);
    inst_sram_req  = gen && ($urandom_range(0, 9) < 7);
    inst_sram_wr   = ($urandom_range(0, 9) == 0);
    inst_sram_size = 2'($urandom_range(0, 2));
    inst_sram_addr = $urandom & 32'hffff_fffc;
    arready        = 1'($urandom_range(0, 1));
    rid            = 4'($urandom);
    rresp          = 2'($urandom);
    if (slv_q.size() != 0 && $urandom_range(0, 1) == 1) begin
      rvalid = 1'b1;
      rdata  = mem_word(slv_q[0]);
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    #1;
    exp_ok = inst_sram_req && !inst_sram_wr && (ar_addr_q.size() == 0) && (out_cnt < MAX);
    chk("addr_ok", inst_sram_addr_ok, exp_ok);
    chk("arvalid", arvalid, ar_addr_q.size() != 0);
    chk("rready", rready, out_cnt != 0);
    chk("data_ok_timing", inst_sram_data_ok, prev_rhs);
    if (ar_addr_q.size() != 0) begin
      chk("araddr", araddr, ar_addr_q[0]);
      chk("arsize", arsize, {1'b0, ar_size_q[0]});
    end
    rhs   = rvalid && (out_cnt != 0);
    ar_hs = (ar_addr_q.size() != 0) && arready;
    if (rhs) begin
      void'(slv_q.pop_front());
      out_cnt--;
    end
    if (ar_hs) begin
      slv_q.push_back(ar_addr_q.pop_front());
      void'(ar_size_q.pop_front());
    end
    if (exp_ok) begin
      ar_addr_q.push_back(inst_sram_addr);
      ar_size_q.push_back(inst_sram_size);
      dat_exp_q.push_back(mem_word(inst_sram_addr));
      out_cnt++;
    end
    prev_rhs = rhs;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("rst_addr_ok", inst_sram_addr_ok, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_data_ok", inst_sram_data_ok, 1'b0);
    chk("rst_rdata", inst_sram_rdata, 32'h0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_arsize", arsize, 3'd0);
    chk("arid", arid, 4'd0);
    chk("arlen", arlen, 8'd0);
    chk("arburst", arburst, 2'b01);
    @(negedge clk);
    reset = 1'b0;

    // Writes are never accepted.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      inst_sram_req = 1'b1; inst_sram_wr = 1'b1; inst_sram_addr = 32'h1000 + 32'(i * 4);
      #1;
      chk("wr_addr_ok", inst_sram_addr_ok, 1'b0);
      chk("wr_arvalid", arvalid, 1'b0);
    end

    // Single fetch with AR backpressure for three cycles.
    @(negedge clk);
    inst_sram_req = 1'b1; inst_sram_wr = 1'b0; inst_sram_size = 2'd2; inst_sram_addr = 32'h1c00_0000;
    #1;
    chk("single_addr_ok", inst_sram_addr_ok, 1'b1);
    dat_exp_q.push_back(32'h0280_0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inst_sram_addr = 32'h2000_0000;
      arready = (i == 3);
      #1;
      chk("bp_arvalid", arvalid, 1'b1);
      chk("bp_araddr", araddr, 32'h1c00_0000);
      chk("bp_arsize", arsize, 3'd2);
      chk("bp_addr_ok", inst_sram_addr_ok, 1'b0);
      chk("bp_rready", rready, 1'b1);
    end
    @(negedge clk);
    inst_sram_req = 1'b0; arready = 1'b0; rvalid = 1'b1; rdata = 32'h0280_0000;
    #1;
    chk("single_arvalid_done", arvalid, 1'b0);
    chk("single_data_ok_early", inst_sram_data_ok, 1'b0);
    @(negedge clk);
    rvalid = 1'b0; rdata = 32'h0;
    #1;
    chk("single_data_ok", inst_sram_data_ok, 1'b1);
    chk("single_rdata", inst_sram_rdata, 32'h0280_0000);
    chk("single_rready_off", rready, 1'b0);
    @(negedge clk);
    #1;
    chk("single_data_ok_pulse", inst_sram_data_ok, 1'b0);
    chk("single_rdata_hold", inst_sram_rdata, 32'h0280_0000);

    // Async reset mid-transaction abandons the in-flight fetch.
    @(negedge clk);
    inst_sram_req = 1'b1; inst_sram_size = 2'd2; inst_sram_addr = 32'h1c00_0040;
    #1;
    chk("rst_mid_addr_ok", inst_sram_addr_ok, 1'b1);
    @(negedge clk);
    inst_sram_req = 1'b0;
    #1;
    chk("rst_mid_arvalid_pre", arvalid, 1'b1);
    chk("rst_mid_rready_pre", rready, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_arvalid", arvalid, 1'b0);
    chk("rst_mid_rready", rready, 1'b0);
    chk("rst_mid_data_ok", inst_sram_data_ok, 1'b0);
    @(negedge clk);
    reset = 1'b0; rvalid = 1'b1; rdata = 32'hdead_beef;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_rready", rready, 1'b0);
      chk("post_rst_data_ok", inst_sram_data_ok, 1'b0);
    end
    idle_inputs();

    // Randomized traffic, then drain everything still in flight.
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
    for (int i = 0; i < 300; i++) begin
      if (ar_addr_q.size() == 0 && slv_q.size() == 0 && dat_exp_q.size() == 0) break;
      rand_cycle(1'b0);
    end
    chk("drain_pending", 32'(ar_addr_q.size() + slv_q.size() + dat_exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
